// File: rtl/id_stage_pipe.sv
// RV32I decode stage: registered, handshaked decode packet with regfile read,
// illegal-encoding detection, load-use bubble insertion and flush.
module id_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int LOAD_USE_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [31:0]      if_ins_i,
    input  logic [XLEN-1:0]  if_addr_i,
    output logic [RA_W-1:0]  rs1_addr_o,
    output logic [RA_W-1:0]  rs2_addr_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [31:0]      ex_ins_o,
    output logic [XLEN-1:0]  ex_addr_o,
    output logic [XLEN-1:0]  ex_src1_o,
    output logic [XLEN-1:0]  ex_src2_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [RA_W-1:0]  ex_rd_addr_o,
    output logic             ex_wb_en_o,
    output logic             ex_mem_rd_o,
    output logic             ex_mem_wr_o,
    output logic             ex_branch_o,
    output logic             ex_jump_o,
    output logic             ex_illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [1:0] {SEL_ZERO, SEL_REG, SEL_ADDR, SEL_IMM} sel_t;

    typedef struct packed {
        logic [31:0]     ins;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rd;
        logic            wb_en;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic            illegal;
    } pkt_t;

    pkt_t             pkt_reg, pkt_next;
    logic             valid_reg;
    logic [CNT_W-1:0] stall_cnt_reg, bubble_cnt_reg;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic            uses_rs1, uses_rs2, has_rd, illegal;
    logic            mem_rd, mem_wr, branch, jump;
    sel_t            src1_sel, src2_sel;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext, rs1_val, rs2_val;
    logic            adv, hazard, accept, stall_inc, bubble_inc;

    assign opcode = if_ins_i[6:0];
    assign rd_f   = if_ins_i[11:7];
    assign funct3 = if_ins_i[14:12];
    assign rs1_f  = if_ins_i[19:15];
    assign rs2_f  = if_ins_i[24:20];
    assign funct7 = if_ins_i[31:25];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        has_rd   = 1'b0;
        illegal  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        src1_sel = SEL_ZERO;
        src2_sel = SEL_ZERO;
        imm32    = '0;
        case (opcode)
            OP_LUI: begin
                has_rd = 1'b1; imm32 = {if_ins_i[31:12], 12'b0}; src2_sel = SEL_IMM;
            end
            OP_AUIPC: begin
                has_rd = 1'b1; imm32 = {if_ins_i[31:12], 12'b0};
                src1_sel = SEL_ADDR; src2_sel = SEL_IMM;
            end
            OP_JAL: begin
                has_rd = 1'b1; jump = 1'b1; src1_sel = SEL_ADDR; src2_sel = SEL_IMM;
                imm32 = {{12{if_ins_i[31]}}, if_ins_i[19:12], if_ins_i[20], if_ins_i[30:21], 1'b0};
            end
            OP_JALR: begin
                has_rd = 1'b1; uses_rs1 = 1'b1; jump = 1'b1;
                src1_sel = SEL_REG; src2_sel = SEL_IMM;
                imm32 = {{20{if_ins_i[31]}}, if_ins_i[31:20]};
                illegal = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; branch = 1'b1;
                src1_sel = SEL_REG; src2_sel = SEL_REG;
                imm32 = {{20{if_ins_i[31]}}, if_ins_i[7], if_ins_i[30:25], if_ins_i[11:8], 1'b0};
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                has_rd = 1'b1; uses_rs1 = 1'b1; mem_rd = 1'b1;
                src1_sel = SEL_REG; src2_sel = SEL_IMM;
                imm32 = {{20{if_ins_i[31]}}, if_ins_i[31:20]};
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; mem_wr = 1'b1;
                src1_sel = SEL_REG; src2_sel = SEL_REG;
                imm32 = {{20{if_ins_i[31]}}, if_ins_i[31:25], if_ins_i[11:7]};
                illegal = (funct3 > 3'b010);
            end
            OP_IMM: begin
                has_rd = 1'b1; uses_rs1 = 1'b1;
                src1_sel = SEL_REG; src2_sel = SEL_IMM;
                imm32 = {{20{if_ins_i[31]}}, if_ins_i[31:20]};
                illegal = ((funct3 == 3'b001) && (funct7 != 7'd0)) ||
                          ((funct3 == 3'b101) && (funct7 != 7'd0) && (funct7 != F7_ALT));
            end
            OP_OP: begin
                has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                src1_sel = SEL_REG; src2_sel = SEL_REG;
                illegal = ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101)) ||
                          ((funct7 != 7'd0) && (funct7 != F7_ALT));
            end
            default: illegal = 1'b1;
        endcase
    end

    // Immediates are formed at 32 bits, then sign-extended to XLEN.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_sext
        if (gi < 32) begin : g_low
            assign imm_ext[gi] = imm32[gi];
        end else begin : g_high
            assign imm_ext[gi] = imm32[31];
        end
    end

    assign rs1_addr_o = uses_rs1 ? RA_W'(rs1_f) : '0;
    assign rs2_addr_o = uses_rs2 ? RA_W'(rs2_f) : '0;
    assign rs1_val    = (rs1_addr_o == '0) ? '0 : rs1_data_i;
    assign rs2_val    = (rs2_addr_o == '0) ? '0 : rs2_data_i;

    always_comb begin
        pkt_next      = '0;
        pkt_next.ins  = if_ins_i;
        pkt_next.addr = if_addr_i;
        pkt_next.imm  = imm_ext;
        if (illegal) begin
            pkt_next.illegal = 1'b1;
        end else begin
            case (src1_sel)
                SEL_REG:  pkt_next.src1 = rs1_val;
                SEL_ADDR: pkt_next.src1 = if_addr_i;
                default:  pkt_next.src1 = '0;
            endcase
            case (src2_sel)
                SEL_REG: pkt_next.src2 = rs2_val;
                SEL_IMM: pkt_next.src2 = imm_ext;
                default: pkt_next.src2 = '0;
            endcase
            pkt_next.rd     = has_rd ? RA_W'(rd_f) : '0;
            pkt_next.wb_en  = has_rd && (rd_f != 5'd0);
            pkt_next.mem_rd = mem_rd;
            pkt_next.mem_wr = mem_wr;
            pkt_next.branch = branch;
            pkt_next.jump   = jump;
        end
    end

    // Unused source addresses are 0 and a hazard needs rd != 0, so a plain compare suffices.
    if (LOAD_USE_EN != 0) begin : g_hazard
        assign hazard = valid_reg && pkt_reg.mem_rd && (pkt_reg.rd != '0) && if_valid_i &&
                        ((rs1_addr_o == pkt_reg.rd) || (rs2_addr_o == pkt_reg.rd));
    end else begin : g_no_hazard
        assign hazard = 1'b0;
    end

    assign adv        = !valid_reg || ex_ready_i;
    assign if_ready_o = adv && !hazard && !flush_i;
    assign accept     = if_valid_i && if_ready_o;
    assign stall_inc  = hazard && !flush_i;
    assign bubble_inc = hazard && adv && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            pkt_reg        <= '0;
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (flush_i) begin
                valid_reg <= 1'b0;
            end else if (adv) begin
                valid_reg <= accept;
                if (accept) pkt_reg <= pkt_next;
            end
            if (stall_inc && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (bubble_inc && (bubble_cnt_reg != '1))
                bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

    assign ex_valid_o   = valid_reg;
    assign ex_ins_o     = pkt_reg.ins;
    assign ex_addr_o    = pkt_reg.addr;
    assign ex_src1_o    = pkt_reg.src1;
    assign ex_src2_o    = pkt_reg.src2;
    assign ex_imm_o     = pkt_reg.imm;
    assign ex_rd_addr_o = pkt_reg.rd;
    assign ex_wb_en_o   = pkt_reg.wb_en;
    assign ex_mem_rd_o  = pkt_reg.mem_rd;
    assign ex_mem_wr_o  = pkt_reg.mem_wr;
    assign ex_branch_o  = pkt_reg.branch;
    assign ex_jump_o    = pkt_reg.jump;
    assign ex_illegal_o = pkt_reg.illegal;
    assign stall_cnt_o  = stall_cnt_reg;
    assign bubble_cnt_o = bubble_cnt_reg;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: hand-decoded expected packets are queued
// on accept and compared when EX consumes them.
module tb_id_stage_pipe;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n, flush_i, if_valid_i, if_ready_o, ex_ready_i, ex_valid_o;
    logic [31:0]      if_ins_i, ex_ins_o;
    logic [XLEN-1:0]  if_addr_i, rs1_data_i, rs2_data_i;
    logic [XLEN-1:0]  ex_addr_o, ex_src1_o, ex_src2_o, ex_imm_o;
    logic [RA_W-1:0]  rs1_addr_o, rs2_addr_o, ex_rd_addr_o;
    logic             ex_wb_en_o, ex_mem_rd_o, ex_mem_wr_o, ex_branch_o, ex_jump_o, ex_illegal_o;
    logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o;

    id_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .LOAD_USE_EN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_ins_i(if_ins_i), .if_addr_i(if_addr_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_ins_o(ex_ins_o), .ex_addr_o(ex_addr_o),
        .ex_src1_o(ex_src1_o), .ex_src2_o(ex_src2_o), .ex_imm_o(ex_imm_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_wb_en_o(ex_wb_en_o), .ex_mem_rd_o(ex_mem_rd_o), .ex_mem_wr_o(ex_mem_wr_o),
        .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .ex_illegal_o(ex_illegal_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    // fl = {wb_en, mem_rd, mem_wr, branch, jump, illegal}
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] addr;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [5:0]  fl;
    } pkt_t;

    pkt_t tbl [14];
    pkt_t exp_q [$];
    pkt_t cur_exp;
    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;
    bit   accepted;
    int   n;

    // Register file: x0 holds garbage so the forced-zero read is visible.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        if (a == 5'd0) return 32'hDEAD_BEEF;
        if (a == 5'd1) return 32'd10;
        return 32'h0001_0000 + 32'(a);
    endfunction

    always_comb begin
        rs1_data_i = rf_val(rs1_addr_o);
        rs2_data_i = rf_val(rs2_addr_o);
    end

    function automatic pkt_t mk(input logic [31:0] ins, addr, src1, src2, imm,
                                input logic [4:0] rd, input logic [5:0] fl);
        pkt_t p;
        p = '{ins: ins, addr: addr, src1: src1, src2: src2, imm: imm, rd: rd, fl: fl};
        return p;
    endfunction

    function automatic pkt_t dut_pkt();
        pkt_t p;
        p = {ex_ins_o, ex_addr_o, ex_src1_o, ex_src2_o, ex_imm_o, ex_rd_addr_o,
             ex_wb_en_o, ex_mem_rd_o, ex_mem_wr_o, ex_branch_o, ex_jump_o, ex_illegal_o};
        return p;
    endfunction

    task automatic check_eq(input string tag, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge with inputs set; evaluates the handshakes, then moves to the next negedge.
    task automatic tick();
        pkt_t e;
        if (rand_ready) ex_ready_i = 1'($urandom_range(0, 1));
        #1;
        if (ex_valid_o && ex_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra", 192'(exp_q.size()), 192'(1));
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("pkt_%h", e.ins), 192'(dut_pkt()), 192'(e));
                $display("txn ins=%h addr=%h src1=%h src2=%h imm=%h rd=%0d fl=%b",
                         ex_ins_o, ex_addr_o, ex_src1_o, ex_src2_o, ex_imm_o, ex_rd_addr_o,
                         {ex_wb_en_o, ex_mem_rd_o, ex_mem_wr_o, ex_branch_o, ex_jump_o, ex_illegal_o});
            end
        end
        accepted = if_valid_i && if_ready_o;
        if (accepted) exp_q.push_back(cur_exp);
        @(negedge clk);
    endtask

    task automatic offer(input pkt_t e, input int max_cyc, output int cycles);
        cycles     = 0;
        cur_exp    = e;
        if_ins_i   = e.ins;
        if_addr_i  = e.addr;
        if_valid_i = 1'b1;
        do begin
            tick();
            cycles++;
        end while (!accepted && cycles < max_cyc);
        if (!accepted) check_eq("accept_timeout", 192'(cycles), 192'(0));
        if_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        if_valid_i = 1'b0;
        rand_ready = 1'b0;
        ex_ready_i = 1'b1;
        while ((exp_q.size() != 0 || ex_valid_o) && k < 20) begin
            tick();
            k++;
        end
        check_eq("drain", 192'(exp_q.size()), 192'(0));
    endtask

    // Holds a packet in EX, then flushes while another instruction is offered.
    task automatic flush_case(input pkt_t held, input pkt_t offered, input string tag);
        int   c;
        pkt_t dropped;
        ex_ready_i = 1'b1;
        offer(held, 10, c);
        ex_ready_i = 1'b0;
        if_ins_i   = offered.ins;
        if_addr_i  = offered.addr;
        if_valid_i = 1'b1;
        flush_i    = 1'b1;
        #1;
        check_eq({tag, "_ready"}, 192'(if_ready_o), 192'(0));
        @(negedge clk);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        if (exp_q.size() != 0) dropped = exp_q.pop_back();
        check_eq({tag, "_valid"}, 192'(ex_valid_o), 192'(0));
        check_eq({tag, "_cnt"}, 192'({stall_cnt_o, bubble_cnt_o}), 192'({16'd1, 16'd1}));
        ex_ready_i = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b0;
        if_ins_i = '0; if_addr_i = '0;

        tbl[0]  = mk(32'hFFD08293, 32'h000, 32'd10,        32'hFFFFFFFD, 32'hFFFFFFFD, 5'd5,  6'b100000); // ADDI x5,x1,-3
        tbl[1]  = mk(32'h00012383, 32'h004, 32'h00010002,  32'h0,        32'h0,        5'd7,  6'b110000); // LW x7,0(x2)
        tbl[2]  = mk(32'h00338433, 32'h008, 32'h00010007,  32'h00010003, 32'h0,        5'd8,  6'b100000); // ADD x8,x7,x3
        tbl[3]  = mk(32'h00208463, 32'h00C, 32'd10,        32'h00010002, 32'h8,        5'd0,  6'b000100); // BEQ x1,x2,+8
        tbl[4]  = mk(32'hFFDFF0EF, 32'h100, 32'h100,       32'hFFFFFFFC, 32'hFFFFFFFC, 5'd1,  6'b100010); // JAL x1,-4
        tbl[5]  = mk(32'h0000007F, 32'h104, 32'h0,         32'h0,        32'h0,        5'd0,  6'b000001); // unknown opcode
        tbl[6]  = mk(32'h403114B3, 32'h108, 32'h0,         32'h0,        32'h0,        5'd0,  6'b000001); // SUB funct3=001
        tbl[7]  = mk(32'h12345537, 32'h10C, 32'h0,         32'h12345000, 32'h12345000, 5'd10, 6'b100000); // LUI x10
        tbl[8]  = mk(32'hFFFFF597, 32'h200, 32'h200,       32'hFFFFF000, 32'hFFFFF000, 5'd11, 6'b100000); // AUIPC x11
        tbl[9]  = mk(32'hFE322C23, 32'h204, 32'h00010004,  32'h00010003, 32'hFFFFFFF8, 5'd0,  6'b001000); // SW x3,-8(x4)
        tbl[10] = mk(32'h4042D613, 32'h208, 32'h00010005,  32'h404,      32'h404,      5'd12, 6'b100000); // SRAI x12,x5,4
        tbl[11] = mk(32'h00008067, 32'h20C, 32'd10,        32'h0,        32'h0,        5'd0,  6'b000010); // JALR x0,0(x1)
        tbl[12] = mk(32'h00017383, 32'h210, 32'h0,         32'h0,        32'h0,        5'd0,  6'b000001); // LOAD funct3=111
        tbl[13] = mk(32'h002006B3, 32'h214, 32'h0,         32'h00010002, 32'h0,        5'd13, 6'b100000); // ADD x13,x0,x2

        repeat (2) @(negedge clk);
        check_eq("rst_pkt", 192'(dut_pkt()), 192'(0));
        check_eq("rst_valid", 192'(ex_valid_o), 192'(0));
        check_eq("rst_cnt", 192'({stall_cnt_o, bubble_cnt_o}), 192'(0));
        rst_n = 1'b1;
        ex_ready_i = 1'b1;

        offer(tbl[0], 10, n);
        check_eq("lat1_valid", 192'(ex_valid_o), 192'(1));
        drain();

        offer(tbl[1], 10, n);
        if_ins_i = tbl[2].ins; if_addr_i = tbl[2].addr; if_valid_i = 1'b1;
        #1;
        check_eq("lu_ready", 192'(if_ready_o), 192'(0));
        offer(tbl[2], 10, n);
        check_eq("lu_cycles", 192'(n), 192'(2));
        check_eq("lu_cnt", 192'({stall_cnt_o, bubble_cnt_o}), 192'({16'd1, 16'd1}));
        drain();

        offer(tbl[3], 10, n);
        ex_ready_i = 1'b0;
        if_ins_i = tbl[4].ins; if_addr_i = tbl[4].addr; if_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("hold_ready", 192'(if_ready_o), 192'(0));
            check_eq("hold_valid", 192'(ex_valid_o), 192'(1));
            check_eq("hold_pkt", 192'(dut_pkt()), 192'(tbl[3]));
            tick();
        end
        drain();

        flush_case(tbl[7], tbl[4], "flush_jal");
        drain();
        flush_case(tbl[1], tbl[2], "flush_hz");
        drain();

        for (int i = 0; i < 14; i++) begin
            offer(tbl[i], 10, n);
            drain();
        end
        check_eq("tbl_cnt", 192'({stall_cnt_o, bubble_cnt_o}), 192'({16'd1, 16'd1}));

        rand_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 14; i++) offer(tbl[i], 50, n);
        drain();

        ex_ready_i = 1'b1;
        offer(tbl[7], 10, n);
        ex_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 192'(ex_valid_o), 192'(0));
        check_eq("arst_pkt", 192'(dut_pkt()), 192'(0));
        check_eq("arst_cnt", 192'({stall_cnt_o, bubble_cnt_o}), 192'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
